// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared funct3 codes, FSM encoding and operation classifiers for mdu_iter
package mdu_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_signed_a(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_iter_dp.sv
// rtl/mdu_iter_dp.sv - one radix-2 iteration: shift-add multiply or restoring divide step
// {hi,lo} is the product register for multiply and {remainder,quotient} for divide.
module mdu_iter_dp #(
   parameter int XLEN = 32
) (
   input  logic            div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
      shifted = {hi_i, lo_i[XLEN-1]};
      diff    = shifted - {1'b0, opnd_i};
      hi_o    = sum[XLEN:1];
      lo_o    = {sum[0], lo_i[XLEN-1:1]};
      if (div_i) begin
         // remainder < divisor keeps a non-negative difference below 2^XLEN,
         // so the top bit alone signals a borrow
         if (!diff[XLEN]) begin
            hi_o = diff[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b1};
         end else begin
            hi_o = shifted[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit with valid/ready handshakes and tag
// Operands are reduced to magnitudes on accept; sign is restored on the final step.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       op_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   input  logic [TAG_W-1:0] tag_in_i,
   input  logic             kill_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_out_o,
   output logic             busy_o
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             neg_q, neg_d;
   logic [XLEN-1:0]  opnd_q, opnd_d;
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic [XLEN-1:0]  result_q, result_d;

   logic [XLEN-1:0]   hi_nxt, lo_nxt;
   logic              a_neg, b_neg, b_zero, ovf, fast;
   logic [XLEN-1:0]   a_mag, b_mag, fast_res;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   div_sel, div_fix, final_res;

   mdu_iter_dp #(.XLEN(XLEN)) u_dp (
      .div_i  (is_div(op_q)),
      .hi_i   (hi_q),
      .lo_i   (lo_q),
      .opnd_i (opnd_q),
      .hi_o   (hi_nxt),
      .lo_o   (lo_nxt)
   );

   always_comb begin
      a_neg  = is_signed_a(op_i) && a_i[XLEN-1];
      b_neg  = is_signed_b(op_i) && b_i[XLEN-1];
      a_mag  = a_neg ? -a_i : a_i;
      b_mag  = b_neg ? -b_i : b_i;
      b_zero = (b_i == '0);
      ovf    = ((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == SMIN) && (b_i == '1);
      fast   = is_div(op_i) && (b_zero || ovf);
      if (b_zero) fast_res = op_i[1] ? a_i : '1;
      else        fast_res = op_i[1] ? '0  : a_i;
   end

   // Sign fix-up on the value the last iteration is about to produce
   always_comb begin
      prod      = {hi_nxt, lo_nxt};
      prod_fix  = neg_q ? -prod : prod;
      div_sel   = op_q[1] ? hi_nxt : lo_nxt;
      div_fix   = neg_q ? -div_sel : div_sel;
      if (is_div(op_q))        final_res = div_fix;
      else if (op_q == OP_MUL) final_res = prod_fix[XLEN-1:0];
      else                     final_res = prod_fix[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      tag_d    = tag_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i && !kill_i) begin
               op_d  = op_i;
               tag_d = tag_in_i;
               cnt_d = '0;
               hi_d  = '0;
               if (is_div(op_i)) begin
                  lo_d   = a_mag;
                  opnd_d = b_mag;
                  neg_d  = op_i[1] ? a_neg : (a_neg ^ b_neg);
               end else begin
                  lo_d   = b_mag;
                  opnd_d = a_mag;
                  neg_d  = a_neg ^ b_neg;
               end
               if (fast) begin
                  result_d = fast_res;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (kill_i) begin
               state_d = ST_IDLE;
            end else begin
               hi_d  = hi_nxt;
               lo_d  = lo_nxt;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  result_d = final_res;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (kill_i || out_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         tag_q    <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
      end
   end

   assign in_ready_o  = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign out_valid_o = (state_q == ST_DONE);
   assign result_o    = result_q;
   assign tag_out_o   = tag_q;

endmodule
